// File: rtl/left_normalizer_if.sv
// Handshake and payload bundle for the left normalizer.
//   slave  : seen by the normalizer (takes the operand, drives the result)
//   master : seen by the upstream/downstream agent
// Signals: in_valid/in_ready plus the operand fields (sum_in, exp_in, sign_in, r_in, s_in),
//          then out_valid/out_ready plus the result fields (mant_out, exp_out, sign_out,
//          r_out, s_out, zero, underflow, overflow).
interface left_normalizer_if #(
  parameter int unsigned N   = 23,
  parameter int unsigned EXP = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N+1:0]   sum_in;
  logic [EXP-1:0] exp_in;
  logic           sign_in;
  logic           r_in;
  logic           s_in;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   mant_out;
  logic [EXP-1:0] exp_out;
  logic           sign_out;
  logic           r_out;
  logic           s_out;
  logic           zero;
  logic           underflow;
  logic           overflow;

  modport slave (
    input  in_valid, sum_in, exp_in, sign_in, r_in, s_in, out_ready,
    output in_ready, out_valid, mant_out, exp_out, sign_out, r_out, s_out,
           zero, underflow, overflow
  );

  modport master (
    output in_valid, sum_in, exp_in, sign_in, r_in, s_in, out_ready,
    input  in_ready, out_valid, mant_out, exp_out, sign_out, r_out, s_out,
           zero, underflow, overflow
  );
endinterface

// File: rtl/left_normalizer.sv
// Post-add normalization stage of the FP adder.
// Takes the raw significand sum (carry, hidden, fraction) with exponent, round and sticky
// bits. On carry-out it shifts right once. Otherwise it shifts left one bit per cycle
// until the hidden bit is set or the exponent reaches the denormal floor.
// Ports: clk, rst (async, active-high); bus (slave modport) carries the in_valid/in_ready
// operand side and the out_valid/out_ready result side. One operation in flight at a time.
module left_normalizer #(
  parameter int unsigned N   = 23,
  parameter int unsigned EXP = 8
) (
  input  logic clk,
  input  logic rst,
  left_normalizer_if.slave bus
);

  localparam logic [EXP-1:0] EXP_ONE = EXP'(1);
  // Carry case overflows once exp_in + 1 would reach the all-ones (inf) code.
  localparam logic [EXP-1:0] EXP_OVF = {{(EXP-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [N:0]     sig_q, sig_d;      // hidden bit + fraction; doubles as the result register
  logic [EXP-1:0] exp_q, exp_d;
  logic           r_q, r_d;
  logic           s_q, s_d;
  logic           sign_q, sign_d;
  logic           zero_q, zero_d;
  logic           uf_q, uf_d;
  logic           of_q, of_d;
  logic           ov_q, ov_d;

  // State and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= '0;
      exp_q   <= '0;
      r_q     <= 1'b0;
      s_q     <= 1'b0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      exp_q   <= exp_d;
      r_q     <= r_d;
      s_q     <= s_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      uf_q    <= uf_d;
      of_q    <= of_d;
      ov_q    <= ov_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    exp_d   = exp_q;
    r_d     = r_q;
    s_d     = s_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    uf_d    = uf_q;
    of_d    = of_q;
    ov_d    = ov_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d = bus.sign_in;
          zero_d = 1'b0;
          uf_d   = 1'b0;
          of_d   = 1'b0;
          if (bus.sum_in == '0 && !bus.r_in && !bus.s_in) begin
            zero_d  = 1'b1;
            sig_d   = '0;
            exp_d   = '0;
            r_d     = 1'b0;
            s_d     = 1'b0;
            ov_d    = 1'b1;
            state_d = DONE;
          end else if (bus.sum_in[N+1]) begin
            if (bus.exp_in >= EXP_OVF) begin
              of_d  = 1'b1;
              exp_d = '1;
              sig_d = '0;
              r_d   = 1'b0;
              s_d   = 1'b0;
            end else begin
              sig_d = bus.sum_in[N+1:1];
              r_d   = bus.sum_in[0];
              s_d   = bus.r_in | bus.s_in;
              exp_d = bus.exp_in + EXP_ONE;
            end
            ov_d    = 1'b1;
            state_d = DONE;
          end else if (bus.exp_in == '0) begin
            // Denormal operands are never shifted; a set hidden bit promotes to exp 1.
            sig_d   = bus.sum_in[N:0];
            r_d     = bus.r_in;
            s_d     = bus.s_in;
            exp_d   = bus.sum_in[N] ? EXP_ONE : '0;
            uf_d    = ~bus.sum_in[N];
            ov_d    = 1'b1;
            state_d = DONE;
          end else begin
            sig_d   = bus.sum_in[N:0];
            r_d     = bus.r_in;
            s_d     = bus.s_in;
            exp_d   = bus.exp_in;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (sig_q[N]) begin
          ov_d    = 1'b1;
          state_d = DONE;
        end else if (exp_q == EXP_ONE) begin
          exp_d   = '0;
          uf_d    = 1'b1;
          ov_d    = 1'b1;
          state_d = DONE;
        end else begin
          // R enters the LSB on the first shift only, since it is cleared afterwards.
          sig_d = {sig_q[N-1:0], r_q};
          r_d   = 1'b0;
          exp_d = exp_q - EXP_ONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = ov_q;
  assign bus.mant_out  = sig_q[N-1:0];
  assign bus.exp_out   = exp_q;
  assign bus.sign_out  = sign_q;
  assign bus.r_out     = r_q;
  assign bus.s_out     = s_q;
  assign bus.zero      = zero_q;
  assign bus.underflow = uf_q;
  assign bus.overflow  = of_q;

endmodule
